benes_cfg_sequencer: RTL and testbench
======================================

# benes_cfg_sequencer

Upstream control stage for the 8x8 Benes network: accepts per-stage switch settings from the software side over a valid/ready word stream and assembles them into a shadow register. On the last word it commits them to an active configuration. On each frame launch it drives every switch stage's `switch_set` bits, skewed one cycle per stage, so each registered switch stage sees the configuration belonging to the frame currently at its inputs. Back-to-back frames may carry different configurations.

## Interface
- `N_PORTS`, default 8: network width; must be a power of two.
- `STAGES`, default 5: switch stages, equal to 2*log2(N_PORTS)-1.
- `SW_PER_STAGE`, default 4: 2x2 switches per stage, equal to N_PORTS/2.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `cfg_valid`  in  1  a configuration word is offered.
- `cfg_ready`  out  1  the block can accept a configuration word.
- `cfg_data`  in  SW_PER_STAGE  switch bits for one stage. Bit j drives switch j; 0 = bar, 1 = cross.
- `cfg_last`  in  1  marks the final word (stage STAGES-1).
- `cfg_err`  out  1  sticky framing error.
- `cfg_err_clr`  in  1  clears `cfg_err` and returns the FSM to IDLE.
- `in_valid`  in  1  frame launch. Frame data reaches the stage-0 switch inputs in the next cycle.
- `sw_set`  out  STAGES*SW_PER_STAGE  switch controls; bits [k*SW_PER_STAGE +: SW_PER_STAGE] go to stage k.
- `out_valid`  out  1  the frame's data is valid at the last-stage outputs.

## Operation
- Configuration words arrive in stage order 0..STAGES-1. Handshake occurs when `cfg_valid && cfg_ready`.
- The FSM has three states: IDLE, LOAD, ERR.
  - IDLE, on handshake:
    - with `cfg_last=0` and STAGES>1: store the word at shadow[0], set `wcnt`=1, go to LOAD.
    - with `cfg_last=1`: framing error, go to ERR.
  - LOAD, on handshake: store the word at shadow[wcnt] and increment `wcnt`.
    - If `wcnt`==STAGES-1 and `cfg_last=1`: commit {word, shadow[STAGES-2:0]} to the active configuration and go to IDLE.
    - If `cfg_last` arrives with `wcnt`!=STAGES-1, or `cfg_last=0` with `wcnt`==STAGES-1: go to ERR. The shadow is discarded and the active configuration is unchanged.
  - ERR: `cfg_ready`=0 and `cfg_err`=1. `cfg_err_clr` moves the FSM to IDLE and clears `wcnt`.
- `cfg_ready` is 1 in IDLE and LOAD.
- The commit takes effect at the clock edge that ends the handshake cycle.
- At launch, the current active configuration is captured into a per-stage skew pipeline. Stage k's bits and a stage-valid flag are delayed so they present during cycle t+1+k.
- A stage slot carrying no frame drives all-0 (bar).
- Frames may launch every cycle, and every in-flight frame keeps its own captured configuration.

## Timing
- Reset values:
  - FSM = IDLE, `wcnt`=0.
  - Shadow and active configuration = 0.
  - All skew-pipeline slots are invalid.
  - `sw_set`=0, `out_valid`=0, `cfg_err`=0, `cfg_ready`=1 from the first cycle after reset.
- All outputs are registered except `cfg_ready`, which is decoded from the state.
- For `in_valid` at cycle t:
  - stage k's `sw_set` bits hold that frame's configuration during cycle t+1+k only;
  - `out_valid` pulses during cycle t+2+STAGES (t+7 at the defaults).
- A commit and a launch in the same cycle: the launch captures the old configuration. A launch one cycle later captures the new one.
- `cfg_err_clr` during a handshake in ERR is impossible, because `cfg_ready`=0. `cfg_err_clr` in IDLE or LOAD is ignored.
- `rst` mid-load discards the shadow. `rst` with frames in flight kills them: no `out_valid` pulses for those frames, and `sw_set` returns to 0 in the next cycle.
- `wcnt` width is $clog2(STAGES). It never exceeds STAGES-1.

## Structure
- `benes_pkg` holds:
  - the localparams N_PORTS, STAGES, SW_PER_STAGE and CFG_W = STAGES*SW_PER_STAGE;
  - the FSM enum `cfg_state_t` {IDLE, LOAD, ERR};
  - the typedef `stage_cfg_t` = logic [SW_PER_STAGE-1:0].
- One sub-module, `cfg_skew_line`: a parameterised delay line of depth k for one stage's `stage_cfg_t` plus its valid flag, with zero output when invalid. It is instantiated once per stage in a generate loop.
- The FSM, shadow and active registers stay in the top module.

## Test plan
- Load words 0x1,0x2,0x4,0x8,0xF with `cfg_last` on the fifth word, then launch at t → `sw_set` stage k equals word k during t+1+k, `out_valid` during t+7, and `sw_set` is 0 elsewhere.
- Launch three back-to-back frames (A, B, A) with a commit between them → each stage shows A, B, A on consecutive cycles with no bleed-over.
- `cfg_last` on the third word → `cfg_err`=1, `cfg_ready`=0, active configuration unchanged. `cfg_err_clr` → IDLE, after which a full reload succeeds.
- Commit handshake and `in_valid` in the same cycle → the frame uses the old configuration, and a frame launched the next cycle uses the new one.
- Assert `rst` two cycles after a launch, mid-load → no `out_valid`, `sw_set`=0, `cfg_err`=0, and the next load starts at stage 0.
- Launch with no prior configuration after reset → all stages 0 (bar) and `out_valid` at t+7.

Source files
------------

// File: rtl/benes_pkg.sv
// Shared constants and types for the 8x8 Benes network configuration path.
package benes_pkg;

  localparam int N_PORTS      = 8;
  localparam int STAGES       = 2 * $clog2(N_PORTS) - 1;
  localparam int SW_PER_STAGE = N_PORTS / 2;
  localparam int CFG_W        = STAGES * SW_PER_STAGE;

  typedef enum logic [1:0] {IDLE, LOAD, ERR} cfg_state_t;

  typedef logic [SW_PER_STAGE-1:0] stage_cfg_t;

endpackage

// File: rtl/benes_cfg_sequencer_skew.sv
// Delay line carrying one stage's switch bits and a slot-valid flag; empty slots hold zero (bar).
module cfg_skew_line
  import benes_pkg::*;
#(
  parameter int W     = SW_PER_STAGE,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_cfg,
  output logic         out_valid,
  output logic [W-1:0] out_cfg
);

  logic [W-1:0]     data_q [DEPTH];
  logic [W-1:0]     data_d [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  // Gating at the entry keeps every register in the line zero whenever its slot is empty.
  always_comb begin
    data_d[0]  = in_valid ? in_cfg : '0;
    valid_d[0] = in_valid;
    for (int i = 1; i < DEPTH; i++) begin
      data_d[i]  = data_q[i-1];
      valid_d[i] = valid_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_cfg   = data_q[DEPTH-1];
  assign out_valid = valid_q[DEPTH-1];

endmodule

// File: rtl/benes_cfg_sequencer.sv
// Assembles per-stage switch words into a shadow register, commits them, and skews the
// active configuration across the switch stages for each launched frame.
module benes_cfg_sequencer #(
  parameter int N_PORTS      = 8,
  parameter int STAGES       = 2 * $clog2(N_PORTS) - 1,
  parameter int SW_PER_STAGE = N_PORTS / 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cfg_valid,
  output logic                           cfg_ready,
  input  logic [SW_PER_STAGE-1:0]        cfg_data,
  input  logic                           cfg_last,
  output logic                           cfg_err,
  input  logic                           cfg_err_clr,
  input  logic                           in_valid,
  output logic [STAGES*SW_PER_STAGE-1:0] sw_set,
  output logic                           out_valid
);
  import benes_pkg::*;

  localparam int TOT_W  = STAGES * SW_PER_STAGE;
  localparam int WCNT_W = $clog2(STAGES);
  localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(STAGES - 1);

  cfg_state_t               state_q, state_d;
  logic [WCNT_W-1:0]        wcnt_q, wcnt_d;
  logic [SW_PER_STAGE-1:0]  shadow_q [STAGES-1];
  logic [SW_PER_STAGE-1:0]  shadow_d [STAGES-1];
  logic [TOT_W-1:0]         active_q, active_d;
  logic                     err_q, err_d;
  logic                     handshake;
  logic [STAGES-1:0]        stage_valid;
  logic [1:0]               tail_q, tail_d;
  logic                     unused_stage_valid;

  assign cfg_ready = (state_q != ERR);
  assign handshake = cfg_valid && cfg_ready;

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    unique case (state_q)
      IDLE: if (handshake) begin
        if (cfg_last) begin
          state_d = ERR;
        end else begin
          shadow_d[0] = cfg_data;
          wcnt_d      = WCNT_W'(1);
          state_d     = LOAD;
        end
      end
      LOAD: if (handshake) begin
        // The final word goes straight into the active image; it never needs a shadow slot.
        if (wcnt_q == LAST_IDX && cfg_last) begin
          for (int i = 0; i < STAGES - 1; i++) active_d[i*SW_PER_STAGE +: SW_PER_STAGE] = shadow_q[i];
          active_d[TOT_W-1 -: SW_PER_STAGE] = cfg_data;
          wcnt_d  = '0;
          state_d = IDLE;
        end else if (cfg_last || wcnt_q == LAST_IDX) begin
          state_d = ERR;
        end else begin
          for (int i = 0; i < STAGES - 1; i++)
            if (wcnt_q == WCNT_W'(i)) shadow_d[i] = cfg_data;
          wcnt_d = WCNT_W'(wcnt_q + 1'b1);
        end
      end
      ERR: if (cfg_err_clr) begin
        wcnt_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    err_d  = (state_d == ERR);
    tail_d = {tail_q[0], stage_valid[STAGES-1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      active_q <= '0;
      err_q    <= 1'b0;
      tail_q   <= '0;
      for (int i = 0; i < STAGES - 1; i++) shadow_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      err_q    <= err_d;
      tail_q   <= tail_d;
    end
  end

  // Stage k sits k+1 registers behind the launch so it lines up with the frame's arrival.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    cfg_skew_line #(
      .W     (SW_PER_STAGE),
      .DEPTH (k + 1)
    ) u_skew (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_cfg    (active_q[k*SW_PER_STAGE +: SW_PER_STAGE]),
      .out_valid (stage_valid[k]),
      .out_cfg   (sw_set[k*SW_PER_STAGE +: SW_PER_STAGE])
    );
  end

  assign unused_stage_valid = ^stage_valid;
  assign cfg_err            = err_q;
  assign out_valid          = tail_q[1];

endmodule

// File: tb/tb_benes_cfg_sequencer.sv
// Randomized self-checking bench for benes_cfg_sequencer against a cycle-history reference model.
module tb_benes_cfg_sequencer;
  import benes_pkg::*;

  localparam int MAXC = 2000;
  localparam int SW   = SW_PER_STAGE;

  typedef struct {
    bit            iv;
    bit            cv;
    logic [SW-1:0] cd;
    bit            cl;
    bit            clr;
    bit            r;
  } stim_t;

  logic             clk = 1'b0;
  logic             rst, cfg_valid, cfg_last, cfg_err_clr, in_valid;
  logic [SW-1:0]    cfg_data;
  logic             cfg_ready, cfg_err, out_valid;
  logic [CFG_W-1:0] sw_set;

  always #5 clk = ~clk;

  benes_cfg_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_data    (cfg_data),
    .cfg_last    (cfg_last),
    .cfg_err     (cfg_err),
    .cfg_err_clr (cfg_err_clr),
    .in_valid    (in_valid),
    .sw_set      (sw_set),
    .out_valid   (out_valid)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // History of what was applied each cycle, plus the configuration a launch would capture.
  bit               h_iv  [MAXC];
  bit               h_rst [MAXC];
  logic [CFG_W-1:0] h_cfg [MAXC];

  logic [CFG_W-1:0] m_active = '0;
  logic [SW-1:0]    m_words[$];
  bit               m_err = 1'b0;
  stim_t            sq[$];

  // A frame launched in cycle t is visible in cycle c unless a reset was applied in between.
  function automatic bit alive(int t, int c);
    if (t < 0) return 1'b0;
    if (!h_iv[t]) return 1'b0;
    for (int i = t; i < c; i++) if (h_rst[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [CFG_W-1:0] exp_sw(int c);
    logic [CFG_W-1:0] r = '0;
    for (int k = 0; k < STAGES; k++)
      if (alive(c - 1 - k, c)) r[k*SW +: SW] = h_cfg[c-1-k][k*SW +: SW];
    return r;
  endfunction

  function automatic bit exp_ov(int c);
    return alive(c - 2 - STAGES, c);
  endfunction

  // Applies one cycle of stimulus, updates the word-list model, and moves to the next cycle.
  task automatic drive(stim_t s);
    if (cyc >= MAXC - 1) begin
      $display("[TB] FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
      $fatal(1, "[TB] cycle budget exhausted");
    end
    in_valid = s.iv; cfg_valid = s.cv; cfg_data = s.cd;
    cfg_last = s.cl; cfg_err_clr = s.clr; rst = s.r;
    h_iv[cyc] = s.iv; h_rst[cyc] = s.r; h_cfg[cyc] = m_active;
    if (s.r) begin
      m_words.delete(); m_err = 1'b0; m_active = '0;
    end else if (m_err) begin
      if (s.clr) begin m_err = 1'b0; m_words.delete(); end
    end else if (s.cv) begin
      m_words.push_back(s.cd);
      if (s.cl) begin
        if (m_words.size() == STAGES)
          for (int k = 0; k < STAGES; k++) m_active[k*SW +: SW] = m_words[k];
        else
          m_err = 1'b1;
        m_words.delete();
      end else if (m_words.size() == STAGES) begin
        m_err = 1'b1;
        m_words.delete();
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic add(bit iv, bit cv, logic [SW-1:0] cd, bit cl, bit clr, bit r);
    stim_t s;
    s.iv = iv; s.cv = cv; s.cd = cd; s.cl = cl; s.clr = clr; s.r = r;
    sq.push_back(s);
  endtask

  task automatic add_load(logic [CFG_W-1:0] c, bit iv);
    for (int k = 0; k < STAGES; k++) add(iv, 1'b1, c[k*SW +: SW], k == STAGES - 1, 1'b0, 1'b0);
  endtask

  task automatic add_idle(int n);
    for (int i = 0; i < n; i++) add(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) add(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    add_idle(3);
    for (int n = 0; n < sq.size(); n++) begin
      if (n >= 1) begin
        vectors++;
        if ({out_valid, sw_set} !== {exp_ov(cyc), exp_sw(cyc)}) begin
          $display("[TB] FAIL reset_data cyc=%0d got ov=%b sw=%h want ov=%b sw=%h", cyc, out_valid, sw_set, exp_ov(cyc), exp_sw(cyc));
          miscompares++;
        end
      end
      drive(sq[n]);
    end
    sq.delete();
    vectors++;
    if ({sw_set, out_valid, cfg_err, cfg_ready} !== {{CFG_W{1'b0}}, 3'b001}) begin
      $display("[TB] FAIL reset_state got sw=%h ov=%b err=%b rdy=%b want sw=0 ov=0 err=0 rdy=1", sw_set, out_valid, cfg_err, cfg_ready);
      miscompares++;
    end
  endtask

  task automatic test_unconfigured_launch();
    add(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    add_idle(STAGES + 4);
    for (int n = 0; n < sq.size(); n++) begin
      vectors++;
      if ({out_valid, sw_set} !== {exp_ov(cyc), exp_sw(cyc)}) begin
        $display("[TB] FAIL unconf_data cyc=%0d got ov=%b sw=%h want ov=%b sw=%h", cyc, out_valid, sw_set, exp_ov(cyc), exp_sw(cyc));
        miscompares++;
      end
      if (n >= 1) begin
        vectors++;
        if ({out_valid, sw_set} !== {(n == STAGES + 2), {CFG_W{1'b0}}}) begin
          $display("[TB] FAIL unconf_bar n=%0d got ov=%b sw=%h want ov=%b sw=0", n, out_valid, sw_set, (n == STAGES + 2));
          miscompares++;
        end
      end
      drive(sq[n]);
    end
    sq.delete();
  endtask

  task automatic test_basic_load();
    logic [SW-1:0] w [STAGES];
    w = '{4'h1, 4'h2, 4'h4, 4'h8, 4'hF};
    for (int k = 0; k < STAGES; k++) add(1'b0, 1'b1, w[k], k == STAGES - 1, 1'b0, 1'b0);
    add(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    add_idle(STAGES + 5);
    for (int n = 0; n < sq.size(); n++) begin
      vectors++;
      if ({out_valid, sw_set, cfg_err, cfg_ready} !== {exp_ov(cyc), exp_sw(cyc), m_err, !m_err}) begin
        $display("[TB] FAIL basic_data cyc=%0d got ov=%b sw=%h err=%b want ov=%b sw=%h err=%b", cyc, out_valid, sw_set, cfg_err, exp_ov(cyc), exp_sw(cyc), m_err);
        miscompares++;
      end
      if (n >= STAGES + 1 && n < 2 * STAGES + 1) begin
        vectors++;
        if (sw_set[(n-STAGES-1)*SW +: SW] !== w[n-STAGES-1]) begin
          $display("[TB] FAIL basic_stage%0d got=%h want=%h", n - STAGES - 1, sw_set[(n-STAGES-1)*SW +: SW], w[n-STAGES-1]);
          miscompares++;
        end
      end
      if (n == 2 * STAGES + 2) begin
        vectors++;
        if (out_valid !== 1'b1) begin
          $display("[TB] FAIL basic_out_valid got=%b want=1", out_valid);
          miscompares++;
        end
      end
      drive(sq[n]);
    end
    sq.delete();
  endtask

  task automatic test_back_to_back();
    logic [CFG_W-1:0] a, b;
    a = CFG_W'($urandom);
    b = CFG_W'($urandom);
    add_load(a, 1'b0);
    add_load(b, 1'b1);
    add_load(a, 1'b1);
    add(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    add_idle(STAGES + 4);
    for (int n = 0; n < sq.size(); n++) begin
      vectors++;
      if ({out_valid, sw_set} !== {exp_ov(cyc), exp_sw(cyc)}) begin
        $display("[TB] FAIL b2b_data cyc=%0d got ov=%b sw=%h want ov=%b sw=%h", cyc, out_valid, sw_set, exp_ov(cyc), exp_sw(cyc));
        miscompares++;
      end
      drive(sq[n]);
    end
    sq.delete();
  endtask

  task automatic test_framing_error();
    logic [CFG_W-1:0] c, d;
    c = CFG_W'($urandom);
    d = CFG_W'($urandom);
    add_load(c, 1'b0);
    for (int k = 0; k < 3; k++) add(1'b0, 1'b1, SW'($urandom), k == 2, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) add(k == 1, 1'b1, SW'($urandom), 1'(k), 1'b0, 1'b0);
    add(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    add(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    add_load(d, 1'b0);
    add(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < STAGES; k++) add(1'b0, 1'b1, SW'($urandom), 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, '0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    add_idle(STAGES + 4);
    for (int n = 0; n < sq.size(); n++) begin
      vectors++;
      if ({out_valid, sw_set} !== {exp_ov(cyc), exp_sw(cyc)}) begin
        $display("[TB] FAIL err_data cyc=%0d got ov=%b sw=%h want ov=%b sw=%h", cyc, out_valid, sw_set, exp_ov(cyc), exp_sw(cyc));
        miscompares++;
      end
      vectors++;
      if ({cfg_err, cfg_ready} !== {m_err, !m_err}) begin
        $display("[TB] FAIL err_flags cyc=%0d got err=%b rdy=%b want err=%b rdy=%b", cyc, cfg_err, cfg_ready, m_err, !m_err);
        miscompares++;
      end
      drive(sq[n]);
    end
    sq.delete();
  endtask

  task automatic test_commit_with_launch();
    logic [CFG_W-1:0] e, f;
    e = CFG_W'($urandom);
    f = CFG_W'($urandom);
    add_load(e, 1'b0);
    for (int k = 0; k < STAGES; k++) add(k == STAGES - 1, 1'b1, f[k*SW +: SW], k == STAGES - 1, 1'b0, 1'b0);
    add(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    add_idle(STAGES + 4);
    for (int n = 0; n < sq.size(); n++) begin
      vectors++;
      if ({out_valid, sw_set} !== {exp_ov(cyc), exp_sw(cyc)}) begin
        $display("[TB] FAIL same_cyc_data cyc=%0d got ov=%b sw=%h want ov=%b sw=%h", cyc, out_valid, sw_set, exp_ov(cyc), exp_sw(cyc));
        miscompares++;
      end
      if (n == 2 * STAGES || n == 2 * STAGES + 1) begin
        vectors++;
        if (sw_set[SW-1:0] !== ((n == 2 * STAGES) ? e[SW-1:0] : f[SW-1:0])) begin
          $display("[TB] FAIL same_cyc_stage0 n=%0d got=%h want=%h", n, sw_set[SW-1:0], (n == 2 * STAGES) ? e[SW-1:0] : f[SW-1:0]);
          miscompares++;
        end
      end
      drive(sq[n]);
    end
    sq.delete();
  endtask

  task automatic test_reset_inflight();
    logic [CFG_W-1:0] g, h;
    g = CFG_W'($urandom) | CFG_W'(1);
    h = CFG_W'($urandom);
    add_load(g, 1'b0);
    add(1'b1, 1'b1, SW'($urandom), 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, SW'($urandom), 1'b0, 1'b0, 1'b0);
    add(1'b0, 1'b1, SW'($urandom), 1'b0, 1'b0, 1'b1);
    add_idle(STAGES + 5);
    add_load(h, 1'b0);
    add(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    add_idle(STAGES + 4);
    for (int n = 0; n < sq.size(); n++) begin
      vectors++;
      if ({out_valid, sw_set, cfg_err, cfg_ready} !== {exp_ov(cyc), exp_sw(cyc), m_err, !m_err}) begin
        $display("[TB] FAIL rst_data cyc=%0d got ov=%b sw=%h err=%b want ov=%b sw=%h err=%b", cyc, out_valid, sw_set, cfg_err, exp_ov(cyc), exp_sw(cyc), m_err);
        miscompares++;
      end
      if (n >= STAGES + 3 && n < 2 * STAGES + 8) begin
        vectors++;
        if ({out_valid, sw_set, cfg_err} !== {(CFG_W + 2){1'b0}}) begin
          $display("[TB] FAIL rst_kill n=%0d got ov=%b sw=%h err=%b want all 0", n, out_valid, sw_set, cfg_err);
          miscompares++;
        end
      end
      drive(sq[n]);
    end
    sq.delete();
  endtask

  task automatic test_random();
    int cnt = 0;
    bit cv, cl, r;
    for (int i = 0; i < 400; i++) begin
      cv = ($urandom_range(3) != 0);
      cl = (cnt == STAGES - 1) ^ ($urandom_range(15) == 0);
      r  = ($urandom_range(99) == 0);
      add($urandom_range(1) == 1, cv, SW'($urandom), cl, $urandom_range(7) == 0, r);
      if (r) cnt = 0;
      else if (cv) cnt = (cl || cnt == STAGES - 1) ? 0 : cnt + 1;
    end
    add_idle(STAGES + 3);
    for (int n = 0; n < sq.size(); n++) begin
      vectors++;
      if ({out_valid, sw_set, cfg_err, cfg_ready} !== {exp_ov(cyc), exp_sw(cyc), m_err, !m_err}) begin
        $display("[TB] FAIL random cyc=%0d got ov=%b sw=%h err=%b rdy=%b want ov=%b sw=%h err=%b", cyc, out_valid, sw_set, cfg_err, cfg_ready, exp_ov(cyc), exp_sw(cyc), m_err);
        miscompares++;
      end
      drive(sq[n]);
    end
    sq.delete();
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_last = 1'b0; cfg_err_clr = 1'b0;
    in_valid = 1'b0; cfg_data = '0;
    @(negedge clk);
    cyc = 0;
    test_reset();
    test_unconfigured_launch();
    test_basic_load();
    test_back_to_back();
    test_framing_error();
    test_commit_with_launch();
    test_reset_inflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
